// File: rtl/window_generator_if.sv
// ---------------------------------------------------------------------------
// window_generator_if
// Pixel-stream input and window output bundle of window_generator.
//
// Parameters:
//   SW  pixel width in bits
//   K   window size (K x K)
//   W,H image width/height (present only with WINGEN_COORD_EN, they size
//       the window-centre coordinate ports)
//
// Signals:
//   sof, pix_valid, pix_in   pixel stream (driven by the master)
//   window_out               [row][col] window, row 0 = oldest line
//   window_valid             window_out holds a complete in-frame window
//   frame_done               1-cycle pulse after the last pixel of a frame
//   win_row, win_col         window centre coordinates (WINGEN_COORD_EN)
//
// Handshake: pix_valid marks a pixel and is taken whenever the block-level
// enable is high; window_valid marks a window that must be consumed in that
// same cycle. There is no ready/backpressure in either direction.
//
// Optional feature macro: WINGEN_COORD_EN
// ---------------------------------------------------------------------------
interface window_generator_if #(
    parameter int SW = 12,
    parameter int K  = 3
`ifdef WINGEN_COORD_EN
    ,
    parameter int W  = 640,
    parameter int H  = 480
`endif
);
    logic                           sof;
    logic                           pix_valid;
    logic [SW-1:0]                  pix_in;
    logic [0:K-1][0:K-1][SW-1:0]    window_out;
    logic                           window_valid;
    logic                           frame_done;
`ifdef WINGEN_COORD_EN
    logic [$clog2(H)-1:0]           win_row;
    logic [$clog2(W)-1:0]           win_col;

    modport master (
        output sof, pix_valid, pix_in,
        input  window_out, window_valid, frame_done, win_row, win_col
    );
    modport slave (
        input  sof, pix_valid, pix_in,
        output window_out, window_valid, frame_done, win_row, win_col
    );
`else
    modport master (
        output sof, pix_valid, pix_in,
        input  window_out, window_valid, frame_done
    );
    modport slave (
        input  sof, pix_valid, pix_in,
        output window_out, window_valid, frame_done
    );
`endif
endinterface

// File: rtl/window_generator.sv
// ---------------------------------------------------------------------------
// window_generator
// Builds a KxK sliding pixel window from a raster-scan pixel stream. The
// previous K-1 rows are kept in line buffers addressed by column; one
// registered window is emitted for each accepted pixel whose window lies
// fully inside the frame.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   en    global clock enable; when low every register (including the line
//         buffers) holds
//   bus   window_generator_if.slave: sof/pix_valid/pix_in in,
//         window_out/window_valid/frame_done (+ win_row/win_col) out
//
// Optional feature macro: WINGEN_COORD_EN adds the window-centre coordinate
// outputs win_row/win_col, updated together with each valid window.
// ---------------------------------------------------------------------------
module window_generator #(
    parameter int C_SIGNAL_WIDTH     = 12,
    parameter int C_KERNEL_DIMENSION = 3,
    parameter int C_IMG_WIDTH        = 640,
    parameter int C_IMG_HEIGHT       = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    window_generator_if.slave  bus
);
    localparam int SW = C_SIGNAL_WIDTH;
    localparam int K  = C_KERNEL_DIMENSION;
    localparam int CW = $clog2(C_IMG_WIDTH);
    localparam int RW = $clog2(C_IMG_HEIGHT);

    logic [CW-1:0]               col_cnt_q, col_cnt_d;
    logic [RW-1:0]               row_cnt_q, row_cnt_d;
    logic [0:K-1][0:K-1][SW-1:0] win_q, win_d;
    logic                        win_valid_q, win_valid_d;
    logic                        frame_done_q, frame_done_d;
`ifdef WINGEN_COORD_EN
    logic [RW-1:0]               win_row_q, win_row_d;
    logic [CW-1:0]               win_col_q, win_col_d;
`endif

    // Line buffer j holds the row that is j+1 rows above the current one.
    // Contents are never reset; they are only read for in-frame windows
    // after being refilled by the current frame.
    logic [SW-1:0] lb_mem [K-1][C_IMG_WIDTH];
    logic [SW-1:0] lb_rd  [K-1];

    logic          accept;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;

    assign accept = en && bus.pix_valid;
    // sof forces the pixel to (0,0) regardless of the running counters.
    assign cur_col = bus.sof ? '0 : col_cnt_q;
    assign cur_row = bus.sof ? '0 : row_cnt_q;

    // Read-before-write: the value at cur_col is still the previous row's.
    always_comb begin
        for (int j = 0; j < K-1; j++) begin
            lb_rd[j] = lb_mem[j][cur_col];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mem[0][cur_col] <= bus.pix_in;
            for (int j = 1; j < K-1; j++) begin
                lb_mem[j][cur_col] <= lb_rd[j-1];
            end
        end
    end

    always_comb begin
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        frame_done_d = frame_done_q;
`ifdef WINGEN_COORD_EN
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
`endif
        if (en) begin
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
            if (bus.pix_valid) begin
                if (cur_col == CW'(C_IMG_WIDTH-1)) begin
                    col_cnt_d = '0;
                    if (cur_row == RW'(C_IMG_HEIGHT-1)) begin
                        row_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        row_cnt_d = cur_row + RW'(1);
                    end
                end else begin
                    col_cnt_d = cur_col + CW'(1);
                    row_cnt_d = cur_row;
                end

                // Shift every row left, then load the new right-hand column:
                // oldest line at row 0, incoming pixel at row K-1.
                for (int i = 0; i < K; i++) begin
                    for (int c = 0; c < K-1; c++) begin
                        win_d[i][c] = win_q[i][c+1];
                    end
                end
                for (int i = 0; i < K-1; i++) begin
                    win_d[i][K-1] = lb_rd[K-2-i];
                end
                win_d[K-1][K-1] = bus.pix_in;

                // Columns left of K-1 would mix in the previous row's tail.
                win_valid_d = (cur_row >= RW'(K-1)) && (cur_col >= CW'(K-1));
`ifdef WINGEN_COORD_EN
                if (win_valid_d) begin
                    win_row_d = cur_row - RW'((K-1)/2);
                    win_col_d = cur_col - CW'((K-1)/2);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef WINGEN_COORD_EN
            win_row_q    <= '0;
            win_col_q    <= '0;
`endif
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
`ifdef WINGEN_COORD_EN
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
`endif
        end
    end

    assign bus.window_out   = win_q;
    assign bus.window_valid = win_valid_q;
    assign bus.frame_done   = frame_done_q;
`ifdef WINGEN_COORD_EN
    assign bus.win_row      = win_row_q;
    assign bus.win_col      = win_col_q;
`endif

endmodule

// File: tb/tb_window_generator.sv
// ---------------------------------------------------------------------------
// tb_window_generator
// Bench for window_generator with W=8, H=6, K=3, 12-bit pixels. Pixel value
// at (r,c) is 16*r + c plus a per-frame offset, so each expected window is
// computed directly from its bottom-right coordinate.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_window_generator;
    localparam int SW   = 12;
    localparam int K    = 3;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int WINW = K*K*SW;
`ifdef WINGEN_COORD_EN
    localparam int RWD  = $clog2(H);
    localparam int CWD  = $clog2(W);
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

`ifdef WINGEN_COORD_EN
    window_generator_if #(.SW(SW), .K(K), .W(W), .H(H)) bus();
`else
    window_generator_if #(.SW(SW), .K(K)) bus();
`endif

    window_generator #(
        .C_SIGNAL_WIDTH(SW),
        .C_KERNEL_DIMENSION(K),
        .C_IMG_WIDTH(W),
        .C_IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    logic [WINW-1:0] exp_q[$];
    logic [WINW-1:0] cur_win;
`ifdef WINGEN_COORD_EN
    logic [RWD+CWD-1:0] crd_q[$];
    logic [RWD+CWD-1:0] cur_crd;
`endif
    logic exp_valid;
    logic exp_fd;
    logic exp_fresh;
    int   checks;
    int   errors;
    int   win_seen;
    int   fd_seen;

    task automatic chk_bit(input string nm, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_win(input string nm, input logic [WINW-1:0] act, input logic [WINW-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [WINW-1:0] mk_win(input int r, input int c, input int off);
        logic [0:K-1][0:K-1][SW-1:0] w;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w[i][j] = SW'(16*(r-K+1+i) + (c-K+1+j) + off);
            end
        end
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change 1ns after the rising edge; expectations for the outputs
    // produced by that edge are set at the same time.
    task automatic send_pix(input int r, input int c, input bit s, input int off);
        en            = 1'b1;
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        bus.pix_in    = SW'(16*r + c + off);
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        exp_fd    = (r == H-1) && (c == W-1);
        exp_valid = (r >= K-1) && (c >= K-1);
        exp_fresh = exp_valid;
        if (exp_valid) begin
            exp_q.push_back(mk_win(r, c, off));
`ifdef WINGEN_COORD_EN
            crd_q.push_back({RWD'(r - (K-1)/2), CWD'(c - (K-1)/2)});
`endif
        end
    endtask

    // e=1: idle cycles (no pixel). e=0: enable low with a junk pixel offered.
    task automatic idle(input int n, input bit e);
        repeat (n) begin
            en            = e;
            bus.pix_valid = !e;
            bus.sof       = 1'($urandom_range(0, 1));
            bus.pix_in    = SW'($urandom_range(0, 4095));
            @(posedge clk); #1;
            if (e) begin
                exp_valid = 1'b0;
                exp_fd    = 1'b0;
            end
            exp_fresh = 1'b0;
        end
        en            = 1'b1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
    endtask

    task automatic send_frame(input int off, input bit gaps, input bit pause);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pix(r, c, (r == 0) && (c == 0), off);
                if (pause && r == 4 && c == 3) idle(3, 1'b0);
                if (gaps) idle(1, 1'b1);
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk_bit("rst_window_valid", bus.window_valid, 1'b0);
                chk_bit("rst_frame_done", bus.frame_done, 1'b0);
                chk_win("rst_window_out", bus.window_out, '0);
`ifdef WINGEN_COORD_EN
                chk_win("rst_coord", WINW'({bus.win_row, bus.win_col}), '0);
`endif
            end else begin
                chk_bit("window_valid", bus.window_valid, exp_valid);
                chk_bit("frame_done", bus.frame_done, exp_fd);
                if (bus.frame_done) fd_seen++;
                if (exp_fresh) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL queue_empty: got no entry expected one at %0t", $time);
                    end else begin
                        cur_win = exp_q.pop_front();
`ifdef WINGEN_COORD_EN
                        cur_crd = crd_q.pop_front();
`endif
                        win_seen++;
                    end
                end
                if (bus.window_valid && exp_valid) begin
                    chk_win("window_out", bus.window_out, cur_win);
`ifdef WINGEN_COORD_EN
                    chk_win("coord", WINW'({bus.win_row, bus.win_col}), WINW'(cur_crd));
`endif
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        int f0;
        checks    = 0;
        errors    = 0;
        win_seen  = 0;
        fd_seen   = 0;
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
        exp_fresh = 1'b0;
        cur_win   = '0;
`ifdef WINGEN_COORD_EN
        cur_crd   = '0;
`endif
        en            = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        rst = 1'b1;
        #2 rst = 1'b0;

        // Reset held while inputs toggle.
        repeat (6) begin
            @(posedge clk); #1;
            en            = 1'($urandom_range(0, 1));
            bus.pix_valid = 1'($urandom_range(0, 1));
            bus.sof       = 1'($urandom_range(0, 1));
            bus.pix_in    = SW'($urandom_range(0, 4095));
        end
        @(posedge clk); #1;
        en            = 1'b1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        rst           = 1'b1;
        idle(2, 1'b1);

        // Full continuous frame (covers first window and row wraps).
        w0 = win_seen; f0 = fd_seen;
        send_frame(0, 1'b0, 1'b0);
        idle(2, 1'b1);
        chk_int("frame_windows", win_seen - w0, (W-K+1)*(H-K+1));
        chk_int("frame_done_count", fd_seen - f0, 1);

        // Same frame with gaps and an enable pause mid-row 4.
        w0 = win_seen; f0 = fd_seen;
        send_frame(0, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk_int("gap_windows", win_seen - w0, (W-K+1)*(H-K+1));
        chk_int("gap_frame_done_count", fd_seen - f0, 1);

        // Partial frame up to pixel (2,5), then restart with fresh data.
        w0 = win_seen; f0 = fd_seen;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < 2 || c <= 5) send_pix(r, c, (r == 0) && (c == 0), 0);
            end
        end
        send_frame(16'h800, 1'b0, 1'b0);
        idle(2, 1'b1);
        chk_int("restart_windows", win_seen - w0, 4 + (W-K+1)*(H-K+1));
        chk_int("restart_frame_done_count", fd_seen - f0, 1);

        chk_int("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
